backtrack_ctrl: RTL and testbench

BACKTRACK_CTRL -- requirements
Module: backtrack_ctrl

---
 rtl/backtrack_ctrl_if.sv | 70 +++++++
 rtl/backtrack_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_backtrack_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/backtrack_ctrl_if.sv
// Bus bundle between backtrack_ctrl and its surroundings: decide/imply request
// handshakes, the trace-table stack port, assignment updates and status.
// master = the controller, slave = the requesters plus the attached stack.
interface backtrack_ctrl_if #(
  parameter int unsigned VARIABLE_INDEXES = 8
);

  // Decide and imply requests with their acks
  logic                        decide_req;
  logic                        decide_val;
  logic [VARIABLE_INDEXES-1:0] decide_var;
  logic                        decide_ack;
  logic                        imply_req;
  logic                        imply_val;
  logic [VARIABLE_INDEXES-1:0] imply_var;
  logic                        imply_ack;
  logic                        conflict;

  // Trace-table stack, write side (type: Decide=0, Forced=1)
  logic                        stk_push;
  logic                        stk_pop;
  logic                        stk_type;
  logic                        stk_val;
  logic [VARIABLE_INDEXES-1:0] stk_var;

  // Trace-table stack, top entry and flags
  logic                        stk_type_out;
  logic                        stk_val_out;
  logic [VARIABLE_INDEXES-1:0] stk_var_out;
  logic                        stk_empty;
  logic                        stk_full;

  // Assignment updates
  logic                        unassign_valid;
  logic [VARIABLE_INDEXES-1:0] unassign_var;
  logic                        assign_valid;
  logic                        assign_val;
  logic [VARIABLE_INDEXES-1:0] assign_var;

  // Status
  logic                        busy;
  logic                        bt_done;
  logic                        unsat;
  logic                        overflow;

  modport master (
    input  decide_req, decide_val, decide_var,
    input  imply_req, imply_val, imply_var,
    input  conflict,
    input  stk_type_out, stk_val_out, stk_var_out, stk_empty, stk_full,
    output decide_ack, imply_ack,
    output stk_push, stk_pop, stk_type, stk_val, stk_var,
    output unassign_valid, unassign_var,
    output assign_valid, assign_val, assign_var,
    output busy, bt_done, unsat, overflow
  );

  modport slave (
    output decide_req, decide_val, decide_var,
    output imply_req, imply_val, imply_var,
    output conflict,
    output stk_type_out, stk_val_out, stk_var_out, stk_empty, stk_full,
    input  decide_ack, imply_ack,
    input  stk_push, stk_pop, stk_type, stk_val, stk_var,
    input  unassign_valid, unassign_var,
    input  assign_valid, assign_val, assign_var,
    input  busy, bt_done, unsat, overflow
  );

endinterface

// File: rtl/backtrack_ctrl.sv
// backtrack_ctrl: chronological-backtracking controller for a trace-table stack.
// In IDLE it pushes Decide/Forced entries (conflict > imply > decide). On a
// conflict it pops Forced entries, unassigning each, until it reaches a Decide
// entry, which it re-pushes flipped as Forced. An empty stack during the pop
// walk means the problem is unsatisfiable and the block parks in UNSAT.
// Stack/ack/assign/unassign outputs are combinational decodes of state and
// inputs, forced low during reset; state, latches and status are registered.
// Optional feature: define BACKTRACK_STATS_EN to add the 16-bit saturating
// bt_count output counting completed backtracks.
module backtrack_ctrl #(
  parameter int unsigned VARIABLE_INDEXES = 8,
  parameter int unsigned NUM_VARIABLE     = 128
) (
  input  logic clock,
  input  logic reset,
  backtrack_ctrl_if.master bus
`ifdef BACKTRACK_STATS_EN
  ,
  output logic [15:0] bt_count
`endif
);

  localparam int unsigned DEPTH_W = $clog2(NUM_VARIABLE + 1);
  localparam logic        TYPE_DECIDE = 1'b0;
  localparam logic        TYPE_FORCED = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BT_POP  = 2'd1,
    BT_FLIP = 2'd2,
    UNSAT   = 2'd3
  } state_t;

  state_t                      state;
  logic                        latched_val;
  logic [VARIABLE_INDEXES-1:0] latched_var;
  logic [DEPTH_W-1:0]          depth_q;
  logic                        busy_q;
  logic                        bt_done_q;
  logic                        unsat_q;
  logic                        overflow_q;

  logic                        full_c;
  logic                        push_c;
  logic                        pop_c;
  logic                        push_type_c;
  logic                        push_val_c;
  logic [VARIABLE_INDEXES-1:0] push_var_c;
  logic                        decide_ack_c;
  logic                        imply_ack_c;
  logic                        unassign_valid_c;
  logic [VARIABLE_INDEXES-1:0] unassign_var_c;
  logic                        assign_valid_c;
  logic                        assign_val_c;
  logic [VARIABLE_INDEXES-1:0] assign_var_c;
  logic                        overflow_set_c;

  // Local occupancy mirrors the stack so a mis-sized stack cannot be overrun
  assign full_c = bus.stk_full | (depth_q == DEPTH_W'(NUM_VARIABLE));

  // Decode the single stack operation and the strobes for this cycle
  always_comb begin
    push_c           = 1'b0;
    pop_c            = 1'b0;
    push_type_c      = TYPE_DECIDE;
    push_val_c       = 1'b0;
    push_var_c       = '0;
    decide_ack_c     = 1'b0;
    imply_ack_c      = 1'b0;
    unassign_valid_c = 1'b0;
    unassign_var_c   = '0;
    assign_valid_c   = 1'b0;
    assign_val_c     = 1'b0;
    assign_var_c     = '0;
    overflow_set_c   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (!bus.conflict) begin
            if (bus.imply_req) begin
              if (full_c) begin
                overflow_set_c = 1'b1;
              end else begin
                push_c      = 1'b1;
                push_type_c = TYPE_FORCED;
                push_val_c  = bus.imply_val;
                push_var_c  = bus.imply_var;
                imply_ack_c = 1'b1;
              end
            end else if (bus.decide_req) begin
              if (full_c) begin
                overflow_set_c = 1'b1;
              end else begin
                push_c       = 1'b1;
                push_type_c  = TYPE_DECIDE;
                push_val_c   = bus.decide_val;
                push_var_c   = bus.decide_var;
                decide_ack_c = 1'b1;
              end
            end
          end
        end
        BT_POP: begin
          if (!bus.stk_empty) begin
            pop_c            = 1'b1;
            unassign_valid_c = 1'b1;
            unassign_var_c   = bus.stk_var_out;
          end
        end
        BT_FLIP: begin
          push_c         = 1'b1;
          push_type_c    = TYPE_FORCED;
          push_val_c     = ~latched_val;
          push_var_c     = latched_var;
          assign_valid_c = 1'b1;
          assign_val_c   = ~latched_val;
          assign_var_c   = latched_var;
        end
        UNSAT: begin
          push_c = 1'b0;
        end
        default: begin
          push_c = 1'b0;
        end
      endcase
    end
  end

  // State, flip latches, occupancy and status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      latched_val <= 1'b0;
      latched_var <= '0;
      depth_q     <= '0;
      busy_q      <= 1'b0;
      bt_done_q   <= 1'b0;
      unsat_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      bt_done_q <= 1'b0;
      if (push_c) begin
        depth_q <= depth_q + DEPTH_W'(1);
      end else if (pop_c) begin
        depth_q <= depth_q - DEPTH_W'(1);
      end
      if (overflow_set_c) begin
        overflow_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.conflict) begin
            state  <= BT_POP;
            busy_q <= 1'b1;
          end
        end
        BT_POP: begin
          if (bus.stk_empty) begin
            state   <= UNSAT;
            busy_q  <= 1'b0;
            unsat_q <= 1'b1;
          end else if (bus.stk_type_out == TYPE_DECIDE) begin
            state       <= BT_FLIP;
            latched_val <= bus.stk_val_out;
            latched_var <= bus.stk_var_out;
            bt_done_q   <= 1'b1;
          end
        end
        BT_FLIP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        UNSAT: begin
          state <= UNSAT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BACKTRACK_STATS_EN
  // Saturating count of completed backtracks
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bt_count <= 16'h0000;
    end else if (bt_done_q && (bt_count != 16'hFFFF)) begin
      bt_count <= bt_count + 16'h0001;
    end
  end
`endif

  assign bus.stk_push       = push_c;
  assign bus.stk_pop        = pop_c;
  assign bus.stk_type       = push_type_c;
  assign bus.stk_val        = push_val_c;
  assign bus.stk_var        = push_var_c;
  assign bus.decide_ack     = decide_ack_c;
  assign bus.imply_ack      = imply_ack_c;
  assign bus.unassign_valid = unassign_valid_c;
  assign bus.unassign_var   = unassign_var_c;
  assign bus.assign_valid   = assign_valid_c;
  assign bus.assign_val     = assign_val_c;
  assign bus.assign_var     = assign_var_c;
  assign bus.busy           = busy_q;
  assign bus.bt_done        = bt_done_q;
  assign bus.unsat          = unsat_q;
  assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Directed bench for backtrack_ctrl with a 4-deep behavioural trace-table stack.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_backtrack_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  backtrack_ctrl_if #(.VARIABLE_INDEXES(8)) bus ();

`ifdef BACKTRACK_STATS_EN
  logic [15:0] bt_count;
`endif

  backtrack_ctrl #(
    .VARIABLE_INDEXES(8),
    .NUM_VARIABLE(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef BACKTRACK_STATS_EN
    ,
    .bt_count(bt_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural stack: entry = {type, val, var}
  logic [9:0] mem [4];
  logic [2:0] cnt;
  logic [9:0] top;

  always_comb begin
    top = 10'd0;
    if (cnt != 3'd0) top = mem[2'(cnt - 3'd1)];
    bus.stk_empty    = (cnt == 3'd0);
    bus.stk_full     = (cnt == 3'd4);
    bus.stk_type_out = top[9];
    bus.stk_val_out  = top[8];
    bus.stk_var_out  = top[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= 3'd0;
    else if (bus.stk_push && cnt != 3'd4) cnt <= cnt + 3'd1;
    else if (bus.stk_pop && cnt != 3'd0) cnt <= cnt - 3'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset && bus.stk_push && cnt != 3'd4)
      mem[2'(cnt)] <= {bus.stk_type, bus.stk_val, bus.stk_var};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic t, input logic v, input logic [7:0] x);
    return {22'd0, t, v, x};
  endfunction

  function automatic logic [31:0] push_ent();
    return {22'd0, bus.stk_type, bus.stk_val, bus.stk_var};
  endfunction

  task automatic clr();
    bus.decide_req = 1'b0; bus.decide_val = 1'b0; bus.decide_var = 8'd0;
    bus.imply_req  = 1'b0; bus.imply_val  = 1'b0; bus.imply_var  = 8'd0;
    bus.conflict   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic decide(input logic v, input logic [7:0] x);
    bus.decide_req = 1'b1; bus.decide_val = v; bus.decide_var = x;
  endtask

  task automatic imply(input logic v, input logic [7:0] x);
    bus.imply_req = 1'b1; bus.imply_val = v; bus.imply_var = x;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Reset: combinational outputs gated even with requests present
    decide(1'b1, 8'd1); bus.conflict = 1'b1; #1;
    chk1("rst_push", bus.stk_push, 1'b0);
    chk1("rst_dack", bus.decide_ack, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_unsat", bus.unsat, 1'b0);
    chk1("rst_ovf", bus.overflow, 1'b0);
    chk1("rst_done", bus.bt_done, 1'b0);
    clr(); reset = 1'b0;
    tick();

    // Backtrack through two Forced entries to Decide var 3
    decide(1'b1, 8'd3); #1;
    chk1("d3_ack", bus.decide_ack, 1'b1);
    chk1("d3_push", bus.stk_push, 1'b1);
    chk("d3_ent", push_ent(), ent(1'b0, 1'b1, 8'd3));
    tick(); clr();
    imply(1'b0, 8'd5); #1;
    chk1("i5_ack", bus.imply_ack, 1'b1);
    chk("i5_ent", push_ent(), ent(1'b1, 1'b0, 8'd5));
    tick(); clr();
    imply(1'b1, 8'd7); #1;
    chk("i7_ent", push_ent(), ent(1'b1, 1'b1, 8'd7));
    tick(); clr();
    bus.conflict = 1'b1; imply(1'b1, 8'd9); #1;
    chk1("cf_push", bus.stk_push, 1'b0);
    chk1("cf_iack", bus.imply_ack, 1'b0);
    tick(); clr();
    decide(1'b0, 8'd20); #1;
    chk1("p1_busy", bus.busy, 1'b1);
    chk1("p1_pop", bus.stk_pop, 1'b1);
    chk1("p1_unv", bus.unassign_valid, 1'b1);
    chk("p1_unvar", 32'(bus.unassign_var), 32'd7);
    chk1("p1_dack", bus.decide_ack, 1'b0);
    chk1("p1_push", bus.stk_push, 1'b0);
    tick(); clr(); #1;
    chk("p2_unvar", 32'(bus.unassign_var), 32'd5);
    chk1("p2_pop", bus.stk_pop, 1'b1);
    tick(); #1;
    chk("p3_unvar", 32'(bus.unassign_var), 32'd3);
    tick(); #1;
    chk1("f1_done", bus.bt_done, 1'b1);
    chk1("f1_push", bus.stk_push, 1'b1);
    chk("f1_ent", push_ent(), ent(1'b1, 1'b0, 8'd3));
    chk1("f1_av", bus.assign_valid, 1'b1);
    chk("f1_avar", 32'(bus.assign_var), 32'd3);
    chk1("f1_aval", bus.assign_val, 1'b0);
    chk1("f1_pop", bus.stk_pop, 1'b0);
    tick(); #1;
    chk1("i1_busy", bus.busy, 1'b0);
    chk1("i1_done", bus.bt_done, 1'b0);
    chk("i1_depth", 32'(cnt), 32'd1);

    // Simultaneous imply and decide: imply first, decide next cycle
    imply(1'b1, 8'd9); decide(1'b0, 8'd10); #1;
    chk1("pr_iack", bus.imply_ack, 1'b1);
    chk1("pr_dack", bus.decide_ack, 1'b0);
    chk("pr_ent", push_ent(), ent(1'b1, 1'b1, 8'd9));
    tick(); bus.imply_req = 1'b0; #1;
    chk1("pr2_dack", bus.decide_ack, 1'b1);
    chk("pr2_ent", push_ent(), ent(1'b0, 1'b0, 8'd10));
    tick(); clr();

    // Second backtrack, Decide on top (single pop)
    bus.conflict = 1'b1;
    tick(); clr(); #1;
    chk("b2_unvar", 32'(bus.unassign_var), 32'd10);
    tick(); #1;
    chk("b2_ent", push_ent(), ent(1'b1, 1'b1, 8'd10));
    chk1("b2_aval", bus.assign_val, 1'b1);
    chk1("b2_done", bus.bt_done, 1'b1);
    tick();

    // Third backtrack
    decide(1'b1, 8'd6);
    tick(); clr();
    bus.conflict = 1'b1;
    tick(); clr(); #1;
    chk("b3_unvar", 32'(bus.unassign_var), 32'd6);
    tick(); #1;
    chk("b3_ent", push_ent(), ent(1'b1, 1'b0, 8'd6));
    tick(); #1;
`ifdef BACKTRACK_STATS_EN
    chk("cnt3", 32'(bt_count), 32'd3);
`endif
    chk("full_depth", 32'(cnt), 32'd4);

    // Overflow on a full stack
    imply(1'b1, 8'd12); #1;
    chk1("ov_push", bus.stk_push, 1'b0);
    chk1("ov_iack", bus.imply_ack, 1'b0);
    chk1("ov_pre", bus.overflow, 1'b0);
    tick(); clr(); #1;
    chk1("ov_set", bus.overflow, 1'b1);
    tick(); #1;
    chk1("ov_sticky", bus.overflow, 1'b1);
    chk("ov_depth", 32'(cnt), 32'd4);

    // Reset in the middle of a pop walk with 3 entries left
    bus.conflict = 1'b1;
    tick(); clr(); #1;
    chk("r_unvar", 32'(bus.unassign_var), 32'd6);
    tick(); #1;
    chk1("r_pop_pre", bus.stk_pop, 1'b1);
    reset = 1'b1; #1;
    chk1("r_pop", bus.stk_pop, 1'b0);
    chk1("r_unv", bus.unassign_valid, 1'b0);
    chk1("r_busy", bus.busy, 1'b0);
    chk1("r_ovf", bus.overflow, 1'b0);
    chk1("r_push", bus.stk_push, 1'b0);
    tick(); #1;
    chk1("r_pop2", bus.stk_pop, 1'b0);
`ifdef BACKTRACK_STATS_EN
    chk("cnt_rst", 32'(bt_count), 32'd0);
`endif
    reset = 1'b0;
    tick(); #1;
    chk1("r_idle_busy", bus.busy, 1'b0);
    chk1("r_idle_pop", bus.stk_pop, 1'b0);

    // Only Forced entries: walk to empty, then UNSAT
    imply(1'b0, 8'd2);
    tick(); clr();
    imply(1'b1, 8'd4);
    tick(); clr();
    bus.conflict = 1'b1;
    tick(); clr(); #1;
    chk("u_unvar4", 32'(bus.unassign_var), 32'd4);
    tick(); #1;
    chk("u_unvar2", 32'(bus.unassign_var), 32'd2);
    tick(); #1;
    chk1("u_empty_pop", bus.stk_pop, 1'b0);
    chk1("u_empty_unv", bus.unassign_valid, 1'b0);
    chk1("u_empty_busy", bus.busy, 1'b1);
    chk1("u_empty_unsat", bus.unsat, 1'b0);
    tick(); #1;
    chk1("u_unsat", bus.unsat, 1'b1);
    chk1("u_busy", bus.busy, 1'b0);
    decide(1'b1, 8'd1); #1;
    chk1("u_dack", bus.decide_ack, 1'b0);
    chk1("u_push", bus.stk_push, 1'b0);
    tick(); tick(); #1;
    chk1("u_unsat2", bus.unsat, 1'b1);
    chk1("u_dack2", bus.decide_ack, 1'b0);
    chk1("u_pop2", bus.stk_pop, 1'b0);
    clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
